// File: rtl/demux_1to16_seq.sv
// demux_1to16_seq
//   Registered 1-to-16 demultiplexer. A width-bit word on `i` is routed,
//   one cycle later, into one of sixteen held channel registers o0..o15.
//   The target is either `sel` (auto = 0) or an internal round-robin
//   pointer `ptr` (auto = 1). Each channel update raises a one-cycle strobe
//   on vld[k]. An auto-mode write to channel 15 wraps the pointer and
//   raises a one-cycle frame_done pulse.
//
// Build option:
//   DEMUX_ZERO_UNSEL_EN  defined  : every accept clears all non-target channels
//                        undefined: non-target channels hold (latching distributor)
//
// Ports:
//   clk         in   clock, all state on rising edge
//   rst_n       in   synchronous active-low reset
//   i           in   [width]   data word
//   in_valid    in   word on i is accepted this cycle
//   sel         in   [swidth]  explicit target when auto = 0
//   auto        in   1: target = ptr, 0: target = sel
//   ptr_clr     in   synchronous clear of ptr
//   o0..o15     out  [width]   channel registers
//   vld         out  [16]      one-hot per-channel update strobe
//   ptr         out  [swidth]  round-robin pointer
//   frame_done  out  pulse when an auto write to channel 15 wraps ptr
module demux_1to16_seq #(
  parameter int width  = 4,
  parameter int swidth = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [width-1:0]  i,
  input  logic              in_valid,
  input  logic [swidth-1:0] sel,
  input  logic              auto,
  input  logic              ptr_clr,
  output logic [width-1:0]  o0,
  output logic [width-1:0]  o1,
  output logic [width-1:0]  o2,
  output logic [width-1:0]  o3,
  output logic [width-1:0]  o4,
  output logic [width-1:0]  o5,
  output logic [width-1:0]  o6,
  output logic [width-1:0]  o7,
  output logic [width-1:0]  o8,
  output logic [width-1:0]  o9,
  output logic [width-1:0]  o10,
  output logic [width-1:0]  o11,
  output logic [width-1:0]  o12,
  output logic [width-1:0]  o13,
  output logic [width-1:0]  o14,
  output logic [width-1:0]  o15,
  output logic [15:0]       vld,
  output logic [swidth-1:0] ptr,
  output logic              frame_done
);

  localparam int unsigned NCH = 16;

  logic [width-1:0]  ch_q [NCH];
  logic [width-1:0]  ch_d [NCH];
  logic [15:0]       vld_q, vld_d;
  logic [swidth-1:0] ptr_q, ptr_d;
  logic              fd_q, fd_d;

  logic [swidth-1:0] tgt;
  logic              auto_acc;

  // In auto mode a same-cycle clear redirects the word to channel 0, so the
  // clear and the write combine into a single pointer step from 0.
  always_comb begin
    tgt      = auto ? (ptr_clr ? '0 : ptr_q) : sel;
    auto_acc = in_valid & auto;
  end

  always_comb begin
    ch_d  = ch_q;
    vld_d = '0;
    ptr_d = ptr_q;
    fd_d  = 1'b0;

    if (in_valid) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (tgt == swidth'(k)) begin
          ch_d[k] = i;
        end else begin
`ifdef DEMUX_ZERO_UNSEL_EN
          ch_d[k] = '0;
`else
          ch_d[k] = ch_q[k];
`endif
        end
      end
      vld_d = 16'(1) << tgt;
    end

    if (auto_acc) begin
      ptr_d = tgt + swidth'(1);
      fd_d  = (tgt == '1);
    end else if (ptr_clr) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_q  <= '{default: '0};
      vld_q <= '0;
      ptr_q <= '0;
      fd_q  <= 1'b0;
    end else begin
      ch_q  <= ch_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
      fd_q  <= fd_d;
    end
  end

  always_comb begin
    o0  = ch_q[0];
    o1  = ch_q[1];
    o2  = ch_q[2];
    o3  = ch_q[3];
    o4  = ch_q[4];
    o5  = ch_q[5];
    o6  = ch_q[6];
    o7  = ch_q[7];
    o8  = ch_q[8];
    o9  = ch_q[9];
    o10 = ch_q[10];
    o11 = ch_q[11];
    o12 = ch_q[12];
    o13 = ch_q[13];
    o14 = ch_q[14];
    o15 = ch_q[15];
    vld        = vld_q;
    ptr        = ptr_q;
    frame_done = fd_q;
  end

endmodule

// File: tb/tb_demux_1to16_seq.sv
// Self-checking bench for demux_1to16_seq: directed scenarios followed by
// random traffic, compared against a channel-array reference model.
module tb_demux_1to16_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i;
  logic        in_valid;
  logic [3:0]  sel;
  logic        auto;
  logic        ptr_clr;
  logic [3:0]  o0, o1, o2, o3, o4, o5, o6, o7;
  logic [3:0]  o8, o9, o10, o11, o12, o13, o14, o15;
  logic [15:0] vld;
  logic [3:0]  ptr;
  logic        frame_done;

  logic [3:0]  dut_o [16];

  int compared = 0;
  int errs     = 0;

  // reference state
  int m_o [16];
  int m_vld;
  int m_ptr;
  int m_fd;

  demux_1to16_seq #(.width(4), .swidth(4)) dut (
    .clk(clk), .rst_n(rst_n), .i(i), .in_valid(in_valid), .sel(sel),
    .auto(auto), .ptr_clr(ptr_clr),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
    .o8(o8), .o9(o9), .o10(o10), .o11(o11), .o12(o12), .o13(o13), .o14(o14),
    .o15(o15), .vld(vld), .ptr(ptr), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    dut_o[0]  = o0;  dut_o[1]  = o1;  dut_o[2]  = o2;  dut_o[3]  = o3;
    dut_o[4]  = o4;  dut_o[5]  = o5;  dut_o[6]  = o6;  dut_o[7]  = o7;
    dut_o[8]  = o8;  dut_o[9]  = o9;  dut_o[10] = o10; dut_o[11] = o11;
    dut_o[12] = o12; dut_o[13] = o13; dut_o[14] = o14; dut_o[15] = o15;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_o[k] = 0;
    m_vld = 0;
    m_ptr = 0;
    m_fd  = 0;
  endtask

  task automatic model_edge(input int r, input int v, input int a,
                            input int s, input int c, input int d);
    int t;
    if (r == 0) begin
      model_reset();
      return;
    end
    m_fd  = 0;
    m_vld = 0;
    if (v != 0) begin
      if (a != 0) t = (c != 0) ? 0 : m_ptr;
      else        t = s;
      for (int k = 0; k < 16; k++) begin
        if (k == t) m_o[k] = d;
`ifdef DEMUX_ZERO_UNSEL_EN
        else m_o[k] = 0;
`endif
      end
      m_vld = 1 << t;
      if (a != 0) begin
        m_ptr = (t + 1) % 16;
        m_fd  = (t == 15) ? 1 : 0;
      end else if (c != 0) begin
        m_ptr = 0;
      end
    end else if (c != 0) begin
      m_ptr = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s_o%0d", tag, k), 32'(dut_o[k]), m_o[k]);
    chk({tag, "_vld"}, 32'(vld), m_vld);
    chk({tag, "_ptr"}, 32'(ptr), m_ptr);
    chk({tag, "_fd"}, 32'(frame_done), m_fd);
  endtask

  // drive one cycle, advance the model on the edge, check 1 time unit later
  task automatic step(input string tag, input int r, input int v, input int a,
                      input int s, input int c, input int d);
    rst_n    = 1'(r);
    in_valid = 1'(v);
    auto     = 1'(a);
    sel      = 4'(s);
    ptr_clr  = 1'(c);
    i        = 4'(d);
    @(posedge clk);
    model_edge(r, v, a, s, c, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; in_valid = 1'b0; auto = 1'b0; sel = '0; ptr_clr = 1'b0; i = '0;
    #1;

    // reset, then explicit select
    step("rst0", 0, 1, 0, 3, 0, 7);
    step("rst1", 0, 0, 0, 0, 0, 0);
    step("sel5", 1, 1, 0, 5, 0, 'hA);
    chk("sel5_o5_lit", 32'(o5), 'hA);
    chk("sel5_vld_lit", 32'(vld), 'h0020);
    chk("sel5_ptr_lit", 32'(ptr), 0);
    step("idle", 1, 0, 0, 0, 0, 0);
    chk("idle_vld_lit", 32'(vld), 0);

    // full auto frame
    for (int n = 0; n < 16; n++) begin
      step($sformatf("frm%0d", n), 1, 1, 1, 0, 0, n);
      chk($sformatf("frm%0d_vld_lit", n), 32'(vld), 1 << n);
      chk($sformatf("frm%0d_fd_lit", n), 32'(frame_done), (n == 15) ? 1 : 0);
    end
    chk("frm_ptr_lit", 32'(ptr), 0);
    step("frm_after", 1, 0, 1, 0, 0, 0);
    chk("frm_after_fd_lit", 32'(frame_done), 0);

    // simultaneous clear with ptr = 7
    step("clr", 1, 0, 0, 0, 1, 0);
    for (int n = 0; n < 7; n++) step($sformatf("pre7_%0d", n), 1, 1, 1, 0, 0, 'hC);
    chk("pre7_ptr_lit", 32'(ptr), 7);
    step("simclr", 1, 1, 1, 0, 1, 3);
    chk("simclr_o0_lit", 32'(o0), 3);
    chk("simclr_vld_lit", 32'(vld), 1);
    chk("simclr_ptr_lit", 32'(ptr), 1);

    // mode switch mid-frame
    step("ms_clr", 1, 0, 0, 0, 1, 0);
    for (int n = 0; n < 3; n++) step($sformatf("ms_a%0d", n), 1, 1, 1, 0, 0, n + 1);
    step("ms_sel12", 1, 1, 0, 12, 0, 9);
    chk("ms_o12_lit", 32'(o12), 9);
    chk("ms_ptr3_lit", 32'(ptr), 3);
    step("ms_auto", 1, 1, 1, 0, 0, 6);
    chk("ms_o3_lit", 32'(o3), 6);
    chk("ms_ptr4_lit", 32'(ptr), 4);

    // mid-frame reset drops the presented word
    for (int n = 0; n < 5; n++) step($sformatf("mr_a%0d", n), 1, 1, 1, 0, 0, 'hF - n);
    step("mr_rst", 0, 1, 1, 0, 0, 'hE);
    chk("mr_ptr_lit", 32'(ptr), 0);
    chk("mr_vld_lit", 32'(vld), 0);
    chk("mr_o5_lit", 32'(o5), 0);

    // non-target channel behaviour
    step("mac_w2", 1, 1, 0, 2, 0, 'hF);
    step("mac_w4", 1, 1, 0, 4, 0, 1);
`ifdef DEMUX_ZERO_UNSEL_EN
    chk("mac_o2_lit", 32'(o2), 0);
`else
    chk("mac_o2_lit", 32'(o2), 'hF);
`endif

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step("rnd",
           ($urandom_range(0, 39) == 0) ? 0 : 1,
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           ($urandom_range(0, 2) != 0) ? 1 : 0,
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 15) == 0) ? 1 : 0,
           int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errs);
    $finish;
  end

endmodule
